// File: rtl/config_pkg.sv
// Shared types for the LSU data-cache port arbiter.
package config_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIeu0,
    StIeu1,
    StHptw
  } arb_state_e;

  function automatic int unsigned llen_in_bytes(input int unsigned llen);
    return llen / 8;
  endfunction

  localparam int unsigned LLENINBYTES = llen_in_bytes(64);

endpackage

// File: rtl/arbstarvecnt.sv
// Saturating count of walker grants made while the IEU is waiting.
module arbstarvecnt #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign at_limit = (cnt_q == CntW'(STARVE_LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_limit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lsu_dcache_arb.sv
// Arbitrates the single D$ port between IEU (one or two spill beats) and the HPTW.
// Optional starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module lsu_dcache_arb
  import config_pkg::*;
#(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned LLEN         = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            FlushM,
  input  logic            IEUReq,
  input  logic            IEUSpill,
  input  logic [XLEN-1:0] IEUAdr,
  input  logic [1:0]      IEURW,
  input  logic            HPTWReq,
  input  logic [XLEN-1:0] HPTWAdr,
  input  logic [1:0]      HPTWRW,
  input  logic            CacheDone,
  output logic            CacheReq,
  output logic [XLEN-1:0] CacheAdr,
  output logic [1:0]      CacheRW,
  output logic            SelHPTW,
  output logic            SelSpill,
  output logic            SpillSave,
  output logic            IEUDone,
  output logic            HPTWDone,
  output logic            IEUStall
);

  localparam logic [XLEN-1:0] BeatInc = XLEN'(llen_in_bytes(LLEN));

  arb_state_e state_q, state_d;
  logic       flush_q, flush_d;
  logic       squash;
  logic       starve_at_limit;

  // A flush seen at any point during an IEU sequence squashes its completion.
  assign squash = FlushM | flush_q;

`ifdef ARB_STARVE_GUARD_EN
  logic hptw_grant, ieu_grant;

  assign hptw_grant = (state_q == StIdle) && (state_d == StHptw);
  assign ieu_grant  = (state_q == StIdle) && (state_d == StIeu0);

  arbstarvecnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (hptw_grant & IEUReq),
    .clr     (ieu_grant),
    .at_limit(starve_at_limit)
  );
`else
  assign starve_at_limit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (HPTWReq && !(IEUReq && starve_at_limit)) begin
          state_d = StHptw;
        end else if (IEUReq) begin
          state_d = StIeu0;
        end
      end
      StIeu0: begin
        if (CacheDone) begin
          state_d = (IEUSpill && !squash) ? StIeu1 : StIdle;
        end
      end
      StIeu1: begin
        if (CacheDone) state_d = StIdle;
      end
      StHptw: begin
        if (CacheDone) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    flush_d = flush_q;
    if (state_d == StIdle) begin
      flush_d = 1'b0;
    end else if ((state_q == StIeu0 || state_q == StIeu1) && FlushM) begin
      flush_d = 1'b1;
    end
  end

  always_comb begin
    CacheReq  = 1'b0;
    CacheAdr  = '0;
    CacheRW   = 2'b00;
    SelHPTW   = 1'b0;
    SelSpill  = 1'b0;
    SpillSave = 1'b0;
    IEUDone   = 1'b0;
    HPTWDone  = 1'b0;
    unique case (state_q)
      StIdle: ;
      StIeu0: begin
        CacheReq  = 1'b1;
        CacheAdr  = IEUAdr;
        CacheRW   = IEURW;
        SpillSave = CacheDone & IEUSpill & ~squash;
        IEUDone   = CacheDone & ~IEUSpill & ~squash;
      end
      StIeu1: begin
        CacheReq = 1'b1;
        CacheAdr = IEUAdr + BeatInc;
        CacheRW  = IEURW;
        SelSpill = 1'b1;
        IEUDone  = CacheDone & ~squash;
      end
      StHptw: begin
        CacheReq = 1'b1;
        CacheAdr = HPTWAdr;
        CacheRW  = HPTWRW;
        SelHPTW  = 1'b1;
        HPTWDone = CacheDone;
      end
      default: ;
    endcase
  end

  // Gated by reset so every output reads zero while reset is held.
  assign IEUStall = IEUReq & ~IEUDone & reset_n;

endmodule

// File: tb/tb_lsu_dcache_arb.sv
// Scoreboard bench for lsu_dcache_arb: expected beats queued by stimulus, popped by a monitor.
module tb_lsu_dcache_arb;

`ifdef ARB_STARVE_GUARD_EN
  localparam bit GuardEn = 1'b1;
`else
  localparam bit GuardEn = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] adr;
    logic [1:0]  rw;
    logic        sel_hptw;
    logic        sel_spill;
    logic        spill_save;
    logic        ieu_done;
    logic        hptw_done;
  } beat_t;

  logic        clk, reset_n, FlushM, IEUReq, IEUSpill, HPTWReq, CacheDone;
  logic [63:0] IEUAdr, HPTWAdr, CacheAdr;
  logic [1:0]  IEURW, HPTWRW, CacheRW;
  logic        CacheReq, SelHPTW, SelSpill, SpillSave, IEUDone, HPTWDone, IEUStall;

  int    checks = 0;
  int    errors = 0;
  int    cache_lat = 1;
  bit    force_done = 0;
  beat_t exp_q[$];

  lsu_dcache_arb #(
    .XLEN(64), .LLEN(64), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .FlushM(FlushM),
    .IEUReq(IEUReq), .IEUSpill(IEUSpill), .IEUAdr(IEUAdr), .IEURW(IEURW),
    .HPTWReq(HPTWReq), .HPTWAdr(HPTWAdr), .HPTWRW(HPTWRW),
    .CacheDone(CacheDone), .CacheReq(CacheReq), .CacheAdr(CacheAdr), .CacheRW(CacheRW),
    .SelHPTW(SelHPTW), .SelSpill(SelSpill), .SpillSave(SpillSave),
    .IEUDone(IEUDone), .HPTWDone(HPTWDone), .IEUStall(IEUStall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cache model: each beat completes after cache_lat cycles on the port.
  initial begin
    int  cnt;
    bit  done_prev;
    cnt = 0;
    done_prev = 0;
    CacheDone = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (done_prev) cnt = 0;
      if (!reset_n) begin
        cnt = 0;
        CacheDone = 1'b0;
      end else if (force_done) begin
        CacheDone = 1'b1;
      end else if (CacheReq) begin
        cnt++;
        CacheDone = (cnt >= cache_lat);
      end else begin
        cnt = 0;
        CacheDone = 1'b0;
      end
      done_prev = CacheReq & CacheDone;
    end
  end

  // Monitor: every completed beat is compared against the head of the expected queue.
  always @(negedge clk) begin
    beat_t act, e;
    if (reset_n) begin
      checks++;
      if ((IEUDone || HPTWDone || SpillSave) && !(CacheReq && CacheDone)) begin
        errors++;
        $display("FAIL done_without_beat: ieu_done=%b hptw_done=%b spill_save=%b, required 0",
                 IEUDone, HPTWDone, SpillSave);
      end
      if (CacheReq && CacheDone) begin
        act = '{CacheAdr, CacheRW, SelHPTW, SelSpill, SpillSave, IEUDone, HPTWDone};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h, required no beat", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL beat: got adr=%h rw=%b hptw=%b spill=%b save=%b idone=%b hdone=%b, required adr=%h rw=%b hptw=%b spill=%b save=%b idone=%b hdone=%b",
                     act.adr, act.rw, act.sel_hptw, act.sel_spill, act.spill_save, act.ieu_done,
                     act.hptw_done, e.adr, e.rw, e.sel_hptw, e.sel_spill, e.spill_save,
                     e.ieu_done, e.hptw_done);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // sel: 0 IEUDone, 1 HPTWDone, 2 IEU0 on port, 3 SelSpill, else beat completing.
  task automatic wait_for(input int sel, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      case (sel)
        0:       ok = IEUDone;
        1:       ok = HPTWDone;
        2:       ok = CacheReq && !SelHPTW && !SelSpill;
        3:       ok = SelSpill;
        default: ok = CacheReq && CacheDone;
      endcase
      if (ok) break;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: event not seen in 50 cycles, required seen", name);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_CacheReq"},  {63'd0, CacheReq},  64'd0);
    chk({tag, "_CacheAdr"},  CacheAdr,           64'd0);
    chk({tag, "_CacheRW"},   {62'd0, CacheRW},   64'd0);
    chk({tag, "_SelHPTW"},   {63'd0, SelHPTW},   64'd0);
    chk({tag, "_SelSpill"},  {63'd0, SelSpill},  64'd0);
    chk({tag, "_SpillSave"}, {63'd0, SpillSave}, 64'd0);
    chk({tag, "_IEUDone"},   {63'd0, IEUDone},   64'd0);
    chk({tag, "_HPTWDone"},  {63'd0, HPTWDone},  64'd0);
    chk({tag, "_IEUStall"},  {63'd0, IEUStall},  64'd0);
  endtask

  initial begin
    int n_h;
    bit got_ieu;
    reset_n = 1'b0; FlushM = 1'b0; IEUReq = 1'b0; IEUSpill = 1'b0; IEUAdr = '0; IEURW = '0;
    HPTWReq = 1'b0; HPTWAdr = '0; HPTWRW = '0;
    #3;
    chk_all_zero("reset");
    #9 reset_n = 1'b1;
    @(negedge clk);

    // Single-beat IEU with CacheDone held high every cycle.
    force_done = 1;
    #1;
    IEUReq = 1'b1; IEUSpill = 1'b0; IEUAdr = 64'h1000; IEURW = 2'b10;
    exp_q.push_back('{64'h1000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    #1 chk("t1_stall_while_waiting", {63'd0, IEUStall}, 64'd1);
    chk("t1_idle_no_req", {63'd0, CacheReq}, 64'd0);
    @(negedge clk);
    chk("t1_req_next_cycle", {63'd0, CacheReq}, 64'd1);
    chk("t1_done_next_cycle", {63'd0, IEUDone}, 64'd1);
    chk("t1_stall_drops", {63'd0, IEUStall}, 64'd0);
    #1 IEUReq = 1'b0;
    @(negedge clk);
    chk("t1_idle_after", {63'd0, CacheReq}, 64'd0);
    chk("t1_idle_adr_zero", CacheAdr, 64'd0);
    force_done = 0;
    @(negedge clk);

    // Spill with 2-cycle latency per beat.
    cache_lat = 2;
    #1;
    IEUReq = 1'b1; IEUSpill = 1'b1; IEUAdr = 64'h1FFD; IEURW = 2'b01;
    exp_q.push_back('{64'h1FFD, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    exp_q.push_back('{64'h2005, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    wait_for(0, "t2_ieu_done");
    #1 IEUReq = 1'b0;
    @(negedge clk);

    // Spill wrapping past all-ones; walker request raised during IEU0 must wait.
    cache_lat = 1;
    #1;
    IEUReq = 1'b1; IEUSpill = 1'b1; IEUAdr = 64'hFFFF_FFFF_FFFF_FFFC; IEURW = 2'b10;
    exp_q.push_back('{64'hFFFF_FFFF_FFFF_FFFC, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    exp_q.push_back('{64'h0000_0000_0000_0004, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    exp_q.push_back('{64'h8000, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    wait_for(2, "t3_ieu0");
    #1 HPTWReq = 1'b1; HPTWAdr = 64'h8000; HPTWRW = 2'b01;
    wait_for(0, "t3_ieu_done");
    #1 IEUReq = 1'b0;
    wait_for(1, "t3_hptw_done");
    #1 HPTWReq = 1'b0;
    @(negedge clk);

    // Both requesters held: count walker grants before the IEU is served.
    #1;
    IEUReq = 1'b1; IEUSpill = 1'b0; IEUAdr = 64'h1100; IEURW = 2'b10;
    HPTWReq = 1'b1; HPTWAdr = 64'h9000; HPTWRW = 2'b01;
    for (int i = 0; i < (GuardEn ? 4 : 10); i++)
      exp_q.push_back('{64'h9000, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    exp_q.push_back('{64'h1100, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    n_h = 0;
    got_ieu = 0;
    for (int i = 0; i < 200 && !got_ieu; i++) begin
      @(negedge clk);
      if (HPTWDone) n_h++;
      if (IEUDone) got_ieu = 1;
      #1;
      if (n_h >= 10) HPTWReq = 1'b0;
      if (got_ieu) begin
        IEUReq = 1'b0;
        HPTWReq = 1'b0;
      end
    end
    chk("t4_hptw_grants_before_ieu", 64'(n_h), GuardEn ? 64'd4 : 64'd10);
    chk("t4_ieu_served", {63'd0, got_ieu}, 64'd1);
    @(negedge clk);

    // Flush pulse during IEU0 of a spill, 3-cycle beat.
    cache_lat = 3;
    #1;
    IEUReq = 1'b1; IEUSpill = 1'b1; IEUAdr = 64'h3000; IEURW = 2'b01;
    exp_q.push_back('{64'h3000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    wait_for(2, "t5_ieu0");
    #1 FlushM = 1'b1;
    @(negedge clk);
    #1 FlushM = 1'b0;
    wait_for(4, "t5_beat_done");
    chk("t5_no_spill_save", {63'd0, SpillSave}, 64'd0);
    chk("t5_no_ieu_done", {63'd0, IEUDone}, 64'd0);
    #1 IEUReq = 1'b0;
    @(negedge clk);
    chk("t5_idle_req", {63'd0, CacheReq}, 64'd0);
    chk("t5_idle_no_spill", {63'd0, SelSpill}, 64'd0);

    // Reset asserted in the middle of IEU1.
    #1;
    IEUReq = 1'b1; IEUSpill = 1'b1; IEUAdr = 64'h5000; IEURW = 2'b10;
    exp_q.push_back('{64'h5000, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    wait_for(3, "t6_ieu1");
    #1 reset_n = 1'b0;
    #1 chk_all_zero("t6_async_reset");
    IEUReq = 1'b0;
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("t6_idle_after_release", {63'd0, CacheReq}, 64'd0);
    @(negedge clk);
    chk("t6_still_idle", {63'd0, CacheReq}, 64'd0);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
